// File: rtl/axis_pattern_pkg.sv
// Shared types and constants for the AXI4-Stream test-pattern generator.
package axis_pattern_pkg;

  localparam int unsigned PIXEL_W = 16;

  typedef enum logic [1:0] {
    PAT_CHECKER = 2'd0,
    PAT_BARS    = 2'd1,
    PAT_RAMP    = 2'd2,
    PAT_SOLID   = 2'd3
  } pattern_mode_e;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } gen_state_e;

  // RGB565: white, yellow, cyan, green, magenta, red, blue, black
  localparam logic [PIXEL_W-1:0] BAR_COLORS [8] = '{
    16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
    16'hF81F, 16'hF800, 16'h001F, 16'h0000
  };

endpackage

// File: rtl/axi4s_if.sv
// AXI4-Stream bundle; zero-width ID/DEST fields collapse to a single tied-off bit.
interface axi4s_if #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned USER_WIDTH = 1,
  parameter int unsigned ID_WIDTH   = 0,
  parameter int unsigned DEST_WIDTH = 0
);
  localparam int unsigned ID_W   = (ID_WIDTH == 0) ? 1 : ID_WIDTH;
  localparam int unsigned DEST_W = (DEST_WIDTH == 0) ? 1 : DEST_WIDTH;

  logic                  tvalid;
  logic                  tready;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [ID_W-1:0]       tid;
  logic [DEST_W-1:0]     tdest;

  modport master (output tvalid, tdata, tlast, tuser, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tuser, tid, tdest, output tready);
endinterface

// File: rtl/pattern_xy_counter.sv
// Pixel coordinate and colour-bar counters; advance on each accepted beat and
// expose the coordinates of the following pixel for look-ahead data generation.
module pattern_xy_counter #(
  parameter int unsigned H_RES = 1024,
  parameter int unsigned V_RES = 768
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       advance_i,
  output logic [$clog2(H_RES)-1:0]   x_nxt_o,
  output logic [$clog2(V_RES)-1:0]   y_nxt_o,
  output logic [2:0]                 bar_nxt_o,
  output logic                       eol_nxt_o,
  output logic                       eof_o
);
  localparam int unsigned XW  = $clog2(H_RES);
  localparam int unsigned YW  = $clog2(V_RES);
  localparam int unsigned SEG = H_RES / 8;
  localparam int unsigned SW  = $clog2(SEG);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [SW-1:0] seg_q, seg_d;
  logic [2:0]    bar_q, bar_d;
  logic          eol_c;

  always_comb begin
    eol_c = (x_q == XW'(H_RES - 1));
    eof_o = eol_c && (y_q == YW'(V_RES - 1));
    x_d   = eol_c ? XW'(0) : x_q + XW'(1);
    y_d   = y_q;
    if (eol_c) y_d = (y_q == YW'(V_RES - 1)) ? YW'(0) : y_q + YW'(1);
    // Bar index steps every H_RES/8 pixels via a segment counter, no divide.
    seg_d = seg_q + SW'(1);
    bar_d = bar_q;
    if (eol_c) begin
      seg_d = SW'(0);
      bar_d = 3'd0;
    end else if (seg_q == SW'(SEG - 1)) begin
      seg_d = SW'(0);
      bar_d = bar_q + 3'd1;
    end
    x_nxt_o   = x_d;
    y_nxt_o   = y_d;
    bar_nxt_o = bar_d;
    eol_nxt_o = (x_d == XW'(H_RES - 1));
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      x_q   <= '0;
      y_q   <= '0;
      seg_q <= '0;
      bar_q <= '0;
    end else if (advance_i) begin
      x_q   <= x_d;
      y_q   <= y_d;
      seg_q <= seg_d;
      bar_q <= bar_d;
    end
  end

endmodule

// File: rtl/axis_pattern_generator.sv
// AXI4-Stream RGB565 test-pattern source: checker, colour bars, grey ramp, solid.
// Mode, colours and enable are captured only at frame start.
module axis_pattern_generator
  import axis_pattern_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned USER_WIDTH  = 1,
  parameter int unsigned ID_WIDTH    = 0,
  parameter int unsigned DEST_WIDTH  = 0,
  parameter int unsigned H_RES       = 1024,
  parameter int unsigned V_RES       = 768,
  parameter int unsigned CELL_W_BITS = 7,
  parameter int unsigned CELL_H_BITS = 6
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          enable_i,
  input  logic [1:0]    mode_i,
  input  logic [15:0]   color1_i,
  input  logic [15:0]   color2_i,
  axi4s_if.master       m_axis,
  output logic          frame_done_o,
  output logic          busy_o
);
  localparam int unsigned XW     = $clog2(H_RES);
  localparam int unsigned YW     = $clog2(V_RES);
  localparam int unsigned ID_W   = (ID_WIDTH == 0) ? 1 : ID_WIDTH;
  localparam int unsigned DEST_W = (DEST_WIDTH == 0) ? 1 : DEST_WIDTH;

  gen_state_e          state_q, state_d;
  pattern_mode_e       mode_q, mode_d;
  logic [PIXEL_W-1:0]  c1_q, c1_d, c2_q, c2_d, tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d, tlast_q, tlast_d, tuser_q, tuser_d;
  logic                done_q, done_d, busy_q, busy_d;
  logic                hs_c, load_c;
  logic [XW-1:0]       x_nxt;
  logic [YW-1:0]       y_nxt;
  logic [2:0]          bar_nxt;
  logic                eol_nxt, eof;

  function automatic logic [PIXEL_W-1:0] pixel_f(pattern_mode_e m, logic [PIXEL_W-1:0] c1,
      logic [PIXEL_W-1:0] c2, logic [XW-1:0] x, logic [YW-1:0] y, logic [2:0] bar);
    logic [XW-1:0] xs;
    logic [YW-1:0] ys;
    xs = x >> CELL_W_BITS;
    ys = y >> CELL_H_BITS;
    case (m)
      PAT_CHECKER: pixel_f = (xs[0] ^ ys[0]) ? c1 : c2;
      PAT_BARS:    pixel_f = BAR_COLORS[bar];
      PAT_RAMP:    pixel_f = {x[XW-1 -: 5], x[XW-1 -: 6], x[XW-1 -: 5]};
      PAT_SOLID:   pixel_f = c1;
      default:     pixel_f = '0;
    endcase
  endfunction

  assign hs_c = tvalid_q & m_axis.tready;

  pattern_xy_counter #(.H_RES(H_RES), .V_RES(V_RES)) u_xy (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (hs_c),
    .x_nxt_o   (x_nxt),
    .y_nxt_o   (y_nxt),
    .bar_nxt_o (bar_nxt),
    .eol_nxt_o (eol_nxt),
    .eof_o     (eof)
  );

  // Next-state and look-ahead output data: the following pixel loads on the handshake edge.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    c1_d     = c1_q;
    c2_d     = c2_q;
    tvalid_d = tvalid_q;
    tdata_d  = tdata_q;
    tlast_d  = tlast_q;
    tuser_d  = tuser_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    load_c   = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable_i) begin
          state_d = STREAM;
          load_c  = 1'b1;
        end
      end
      STREAM: begin
        if (hs_c && eof) begin
          done_d = 1'b1;
          if (enable_i) begin
            load_c = 1'b1;
          end else begin
            state_d  = IDLE;
            tvalid_d = 1'b0;
            tdata_d  = '0;
            tlast_d  = 1'b0;
            tuser_d  = 1'b0;
            busy_d   = 1'b0;
          end
        end else if (hs_c) begin
          tdata_d = pixel_f(mode_q, c1_q, c2_q, x_nxt, y_nxt, bar_nxt);
          tlast_d = eol_nxt;
          tuser_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_c) begin
      mode_d   = pattern_mode_e'(mode_i);
      c1_d     = color1_i;
      c2_d     = color2_i;
      tvalid_d = 1'b1;
      busy_d   = 1'b1;
      tdata_d  = pixel_f(pattern_mode_e'(mode_i), color1_i, color2_i, XW'(0), YW'(0), 3'd0);
      tlast_d  = 1'b0;
      tuser_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      mode_q   <= PAT_CHECKER;
      c1_q     <= '0;
      c2_q     <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      c1_q     <= c1_d;
      c2_q     <= c2_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tlast_q  <= tlast_d;
      tuser_q  <= tuser_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tdata  = DATA_WIDTH'(tdata_q);
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tuser  = USER_WIDTH'(tuser_q);
  assign m_axis.tid    = ID_W'(0);
  assign m_axis.tdest  = DEST_W'(0);
  assign frame_done_o  = done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_axis_pattern_generator.sv
// Scoreboard bench for axis_pattern_generator: expected frames come from a
// coordinate-level pattern model; a negedge monitor pops and compares each beat.
module tb_axis_pattern_generator;
  localparam int H = 64;
  localparam int V = 4;
  localparam int CW = 3;
  localparam int CH = 1;
  localparam int FRAME = H * V;

  typedef struct {
    logic [15:0] data;
    logic        last;
    logic        sof;
    logic        eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst_n, enable;
  logic [1:0]  mode;
  logic [15:0] c1, c2;
  logic        frame_done, busy;
  bit          rand_ready = 1'b0;

  beat_t exp_q[$];
  int    hs_cyc[$];
  int    checks = 0, passed = 0;
  int    beats = 0, cyc = 0, done_seen = 0;
  bit    pend_eof = 1'b0, stalled = 1'b0;
  logic [17:0] held;
  logic [15:0] bar_ref [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                               16'hF81F, 16'hF800, 16'h001F, 16'h0000};

  axi4s_if #(.DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0)) axis ();

  axis_pattern_generator #(
    .DATA_WIDTH(16), .USER_WIDTH(1), .ID_WIDTH(0), .DEST_WIDTH(0),
    .H_RES(H), .V_RES(V), .CELL_W_BITS(CW), .CELL_H_BITS(CH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .enable_i     (enable),
    .mode_i       (mode),
    .color1_i     (c1),
    .color2_i     (c2),
    .m_axis       (axis),
    .frame_done_o (frame_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [15:0] ref_pixel(int m, logic [15:0] k1, logic [15:0] k2, int x, int y);
    int r, g;
    case (m)
      0: return (((x / (1 << CW)) % 2) != ((y / (1 << CH)) % 2)) ? k1 : k2;
      1: return bar_ref[x / (H / 8)];
      2: begin
        r = x * 32 / H;
        g = x * 64 / H;
        return 16'((r << 11) | (g << 5) | r);
      end
      default: return k1;
    endcase
  endfunction

  task automatic push_frame(input int m, input logic [15:0] k1, input logic [15:0] k2);
    beat_t b;
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        b.data = ref_pixel(m, k1, k2, x, y);
        b.last = (x == H - 1);
        b.sof  = (x == 0 && y == 0);
        b.eof  = (x == H - 1 && y == V - 1);
        exp_q.push_back(b);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int n, input int budget);
    int k = 0;
    while (beats < n && k < budget) begin
      tick();
      k++;
    end
    if (beats < n) check("beat_timeout", 32'(beats), 32'(n));
  endtask

  // Ready driver: always ready, or a 50% coin toss per cycle.
  initial begin
    axis.tready = 1'b1;
    forever begin
      tick();
      axis.tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: compares accepted beats, stall stability and frame_done timing.
  always @(negedge clk) begin
    beat_t e;
    if (!rst_n) begin
      pend_eof = 1'b0;
      stalled  = 1'b0;
    end else begin
      if (pend_eof || frame_done) check("frame_done", 32'(frame_done), 32'(pend_eof));
      if (frame_done) done_seen++;
      pend_eof = 1'b0;
      if (stalled) begin
        check("stall_valid", 32'(axis.tvalid), 32'd1);
        check("stall_hold", 32'({axis.tdata, axis.tlast, axis.tuser}), 32'(held));
      end
      stalled = axis.tvalid && !axis.tready;
      held = {axis.tdata, axis.tlast, axis.tuser};
      if (axis.tvalid && axis.tready) begin
        if (exp_q.size() == 0) begin
          check("spurious_beat", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("beat", 32'({axis.tdata, axis.tlast, axis.tuser, axis.tid, axis.tdest}),
                32'({e.data, e.last, e.sof, 2'b00}));
          pend_eof = e.eof;
        end
        beats++;
        hs_cyc.push_back(cyc);
      end
    end
  end

  initial begin
    int b0;
    rst_n = 1'b0; enable = 1'b0; mode = 2'd0; c1 = 16'hF800; c2 = 16'h001F;
    repeat (3) tick();
    check("rst_tvalid", 32'(axis.tvalid), 0);
    check("rst_tdata", 32'(axis.tdata), 0);
    check("rst_tlast", 32'(axis.tlast), 0);
    check("rst_tuser", 32'(axis.tuser), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(frame_done), 0);
    rst_n = 1'b1;
    repeat (2) tick();
    check("idle_no_valid", 32'(axis.tvalid), 0);

    // Frame A checker, then a mid-frame switch to solid for frame B.
    push_frame(0, 16'hF800, 16'h001F);
    enable = 1'b1;
    tick();
    check("start_valid", 32'(axis.tvalid), 1);
    check("start_sof", 32'(axis.tuser), 1);
    check("start_busy", 32'(busy), 1);
    wait_beats(100, 1000);
    mode = 2'd3; c1 = 16'h07E0; c2 = 16'h1234;
    push_frame(3, 16'h07E0, 16'h1234);
    wait_beats(300, 1000);
    check("no_bubble", 32'(hs_cyc[299] - hs_cyc[0]), 32'd299);
    check("frame_seam", 32'(hs_cyc[FRAME] - hs_cyc[FRAME - 1]), 32'd1);

    // Bars then ramp under random backpressure, disable mid-ramp.
    mode = 2'd1;
    push_frame(1, 16'h07E0, 16'h1234);
    rand_ready = 1'b1;
    wait_beats(600, 5000);
    mode = 2'd2;
    push_frame(2, 16'h07E0, 16'h1234);
    wait_beats(800, 5000);
    enable = 1'b0;
    wait_beats(4 * FRAME, 5000);
    repeat (3) tick();
    check("end_tvalid", 32'(axis.tvalid), 0);
    check("end_busy", 32'(busy), 0);
    check("done_count4", 32'(done_seen), 32'd4);

    // Re-enable with bars, then reset mid-line.
    rand_ready = 1'b0;
    mode = 2'd1;
    push_frame(1, 16'h07E0, 16'h1234);
    enable = 1'b1;
    tick();
    check("reen_valid", 32'(axis.tvalid), 1);
    check("reen_sof", 32'(axis.tuser), 1);
    wait_beats(4 * FRAME + 130, 1000);
    check("pre_rst_valid", 32'(axis.tvalid), 1);
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(axis.tvalid), 0);
    check("async_rst_busy", 32'(busy), 0);
    exp_q.delete();
    mode = 2'd0; c1 = 16'hAAAA; c2 = 16'h5555;
    push_frame(0, 16'hAAAA, 16'h5555);
    tick();
    rst_n = 1'b1;
    b0 = beats;
    tick();
    check("post_rst_valid", 32'(axis.tvalid), 1);
    check("post_rst_sof", 32'(axis.tuser), 1);
    wait_beats(b0 + 150, 2000);
    enable = 1'b0;
    rand_ready = 1'b1;
    wait_beats(b0 + FRAME, 5000);
    repeat (3) tick();
    check("final_tvalid", 32'(axis.tvalid), 0);
    check("final_busy", 32'(busy), 0);
    check("done_count5", 32'(done_seen), 32'd5);
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/axis_pattern_generator.md
# axis_pattern_generator

Parametrised AXI4-Stream video test-pattern source: the next generation of our checkerboard generator. It produces RGB565 frames of H_RES×V_RES pixels in one of four runtime-selectable patterns: checkerboard, 8 colour bars, horizontal ramp, and solid colour. It generates its own X/Y counters, fully honours TREADY backpressure, and switches mode or enable only on frame boundaries. It sits at the head of the video path, feeding the stream-to-VGA/HDMI pipeline for bring-up and FIFO-underflow diagnosis.

## Interface
- DATA_WIDTH, 16: TDATA width; must be 16 (RGB565).
- USER_WIDTH, 1: TUSER width; bit 0 is start-of-frame (SOF), other bits are driven 0.
- ID_WIDTH, 0 / DEST_WIDTH, 0: passed to the interface; TID/TDEST are driven 0.
- H_RES, 1024: pixels per line; must be a multiple of 8 and ≥64.
- V_RES, 768: lines per frame; ≥2.
- CELL_W_BITS, 7 / CELL_H_BITS, 6: checker cell is 2^CELL_W_BITS × 2^CELL_H_BITS pixels.
- clk_i  in  1  pixel clock; the only clock.
- rst_ni  in  1  asynchronous, active-low reset.
- enable_i  in  1  stream enable; sampled only at frame start.
- mode_i  in  2  pattern select (0 checker, 1 bars, 2 ramp, 3 solid); sampled only at frame start.
- color1_i / color2_i  in  16  checker colours (colour1 when cell parities differ); color1_i is also the solid colour. Sampled at frame start.
- m_axis  axi4s_if.master  —  TVALID, TREADY, TDATA, TLAST, TUSER.
- frame_done_o  out  1  one-cycle pulse on the handshake of the last pixel of a frame.
- busy_o  out  1  high while a frame is in progress.

## Operation
- States: IDLE, STREAM.
  - IDLE → STREAM when enable_i=1. On this transition latch mode, colours, x=0, y=0, and present pixel (0,0) with SOF.
  - STREAM → IDLE after the handshake of pixel (H_RES-1, V_RES-1) if enable_i=0 in that cycle.
  - Otherwise the next frame starts back-to-back with freshly latched mode and colours.
- Coordinates advance only on a handshake (TVALID & TREADY).
  - x wraps H_RES-1 → 0 and increments y.
  - y wraps V_RES-1 → 0.
- TLAST = 1 when x = H_RES-1. TUSER[0] = 1 only when x=0 and y=0.
- Checker: colour1 if (x>>CELL_W_BITS)[0] ^ (y>>CELL_H_BITS)[0], else colour2.
- Bars: index 0..7 held in a bar counter that increments every H_RES/8 pixels. No divider. The counter resets with x.
  - Colours in order: white FFFF, yellow FFE0, cyan 07FF, green 07E0, magenta F81F, red F800, blue 001F, black 0000.
- Ramp: R = x[MSB-:5], G = x[MSB-:6], B = x[MSB-:5] (grey ramp), where MSB = $clog2(H_RES)-1.
- Solid: color1 every pixel.
- Mid-frame changes to enable_i, mode_i or colours have no effect until the next frame start.

## Timing
- All outputs are registered. Reset values: TVALID=0, TDATA=0, TLAST=0, TUSER=0, frame_done_o=0, busy_o=0, state=IDLE, x=y=0, bar counter 0.
- Latency: if enable_i is high at edge N in IDLE, then TVALID=1 with pixel (0,0) and SOF after edge N. busy_o rises on the same edge.
- While TVALID=1 and TREADY=0, TDATA/TLAST/TUSER hold stable. TVALID never drops without a handshake.
- With TREADY held high, one pixel is transferred per cycle with no bubbles, including across line and frame boundaries.
- The next pixel's data is computed from the next coordinates and loaded on the handshake edge, giving zero-bubble throughput without a skid buffer.
- frame_done_o pulses on the edge after the last-pixel handshake. busy_o falls on that same edge when going to IDLE.
- Asserting rst_ni low at any time, including mid-frame or with TVALID high, immediately forces the reset values. The next frame starts at (0,0) with SOF.

## Structure
- Package axis_pattern_pkg:
  - pattern_mode_e enum (PAT_CHECKER, PAT_BARS, PAT_RAMP, PAT_SOLID);
  - BAR_COLORS[8] RGB565 constant array;
  - gen_state_e (IDLE, STREAM).
- Sub-module pattern_xy_counter: x/y/bar counters with advance input; outputs next-coordinates, end-of-line and end-of-frame flags.
- The colour mux stays in the top module.

## Test plan
- H_RES=64, V_RES=4, mode 0, CELL 3/1, TREADY=1: 256 beats; TLAST on every 64th beat; SOF only on beat 0; pixel (8,0)=color1, (8,2)=color2; frame_done_o pulses once.
- Mode 1, H_RES=64: pixels x=0..7 = FFFF, x=8 = FFE0, x=56..63 = 0000; repeated every line.
- Random TREADY (50%): data/TLAST/TUSER stable during stalls; beat sequence identical to the TREADY=1 run.
- mode_i changed 0→3 mid-frame: current frame stays checker; the next frame (SOF) is all color1; no gap between frames when TREADY=1.
- enable_i dropped mid-frame: the frame completes and then TVALID=0 and busy_o=0. Re-enable: SOF at (0,0) one cycle later.
- rst_ni pulsed low mid-line with TVALID=1: TVALID=0 at once. After release with enable_i high, the first beat is (0,0) with SOF.
